// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO with a valid/ready push port.
// Frames are sent back-to-back with no idle bit time whenever the FIFO still holds data.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [7:0]                         tx_data_i,
    input  logic                               tx_valid_i,
    output logic                               tx_ready_o,
    output logic                               tx_o,
    output logic                               busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  COUNT_ZERO = '0;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [7:0]          shift_reg;
    logic                tx_reg, tx_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          bit_reg, bit_next;
    logic                shift_en;
    logic                push;
    logic                pop;
    logic                baud_done;
    logic                fifo_empty;

    assign fifo_empty = (count_reg == COUNT_ZERO);
    assign tx_ready_o = rst_ni && (count_reg != COUNT_FULL);
    assign push       = tx_valid_i && tx_ready_o;
    assign baud_done  = (baud_reg == BAUD_LAST);

    // The only way into START is a pop, whether from IDLE or straight out of STOP.
    assign pop = (state_next == START) && (state_reg != START);

    assign tx_o         = tx_reg;
    assign busy_o       = (state_reg != IDLE) || !fifo_empty;
    assign fifo_count_o = count_reg;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_done && (bit_reg == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_next = fifo_empty ? IDLE : START;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        tx_next   = tx_reg;
        bit_next  = bit_reg;
        shift_en  = 1'b0;
        baud_next = (state_reg == IDLE || baud_done) ? '0 : baud_reg + 1'b1;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
            end
            START: begin
                if (baud_done) begin
                    tx_next  = shift_reg[0];
                    bit_next = 3'd0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_reg == 3'd7) begin
                        tx_next = 1'b1;
                    end else begin
                        tx_next  = shift_reg[1];
                        shift_en = 1'b1;
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
            end
            default: tx_next = 1'b1;
        endcase
        if (pop) begin
            tx_next   = 1'b0;
            baud_next = '0;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage array has no reset so it maps onto plain RAM; the read lands in shift_reg.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            baud_reg   <= '0;
            bit_reg    <= '0;
        end else begin
            count_reg <= count_next;
            tx_reg    <= tx_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                shift_reg  <= mem[rd_ptr_reg];
            end else if (shift_en) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit and a 4-entry FIFO.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ_HZ = 1_000_000;
    localparam int BAUD_RATE   = 100_000;
    localparam int FIFO_DEPTH  = 4;
    localparam int CPB         = 10;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] fifo_count_o;

    int checks = 0;
    int passes = 0;

    uart_tx_fifo #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .fifo_count_o(fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Offer a byte until accepted; returns the number of stalled cycles.
    task automatic push(input logic [7:0] b, output int waited);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        waited     = 0;
        while (!tx_ready_o && waited < 2000) begin
            @(negedge clk_i);
            waited++;
        end
        if (waited >= 2000) begin
            checks++;
            $display("FAIL push_timeout: byte %h not accepted after %0d cycles, required acceptance", b, waited);
        end
        @(negedge clk_i);
        tx_valid_i = 1'b0;
    endtask

    // Wait up to wait_max cycles for the start bit, then check all ten bit times cycle by cycle.
    task automatic check_frame(input logic [7:0] b, input int wait_max);
        logic [9:0] bits;
        int         w;
        int         bad;
        bits = {1'b1, b, 1'b0};
        w    = 0;
        while (tx_o !== 1'b0 && w < wait_max) begin
            @(negedge clk_i);
            w++;
        end
        checks++;
        if (tx_o !== 1'b0) begin
            $display("FAIL frame_start_%h: tx_o=%b after %0d cycles, required 0", b, tx_o, w);
        end else begin
            passes++;
        end
        for (int i = 0; i < 10; i++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                if (tx_o !== bits[i]) bad++;
                @(negedge clk_i);
            end
            checks++;
            if (bad != 0) begin
                $display("FAIL frame_%h_bit%0d: %0d of %0d cycles wrong, required level %b", b, i, bad, CPB, bits[i]);
            end else begin
                passes++;
            end
        end
        $display("frame %h checked", b);
    endtask

    task automatic test_reset();
        rst_ni     = 1'b0;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({tx_o, tx_ready_o, busy_o, fifo_count_o} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            $display("FAIL reset_outputs: tx/ready/busy/count=%b/%b/%b/%0d, required 1/0/0/0", tx_o, tx_ready_o, busy_o, fifo_count_o);
        end else begin
            passes++;
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({tx_o, tx_ready_o, busy_o} !== 3'b110) begin
            $display("FAIL reset_release: tx/ready/busy=%b/%b/%b, required 1/1/0", tx_o, tx_ready_o, busy_o);
        end else begin
            passes++;
        end
        $display("reset test done");
    endtask

    task automatic test_single_byte();
        int w;
        push(8'hA5, w);
        checks++;
        if ({tx_o, fifo_count_o} !== {1'b1, 3'd1}) begin
            $display("FAIL single_after_push: tx/count=%b/%0d, required 1/1", tx_o, fifo_count_o);
        end else begin
            passes++;
        end
        @(negedge clk_i);
        check_frame(8'hA5, 0);
        checks++;
        if ({busy_o, tx_o, fifo_count_o} !== {1'b0, 1'b1, 3'd0}) begin
            $display("FAIL single_done: busy/tx/count=%b/%b/%0d, required 0/1/0", busy_o, tx_o, fifo_count_o);
        end else begin
            passes++;
        end
    endtask

    task automatic test_back_to_back();
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b1;
        fork
            begin
                @(negedge clk_i);
                checks++;
                if (fifo_count_o !== 3'd1) $display("FAIL b2b_count_e1: got %0d, required 1", fifo_count_o);
                else passes++;
                tx_data_i = 8'hFF;
                @(negedge clk_i);
                checks++;
                if (fifo_count_o !== 3'd1) $display("FAIL b2b_count_e2: got %0d, required 1", fifo_count_o);
                else passes++;
                tx_data_i = 8'h3C;
                @(negedge clk_i);
                checks++;
                if (fifo_count_o !== 3'd2) $display("FAIL b2b_count_e3: got %0d, required 2", fifo_count_o);
                else passes++;
                tx_valid_i = 1'b0;
            end
            begin
                check_frame(8'h00, 3);
                checks++;
                if (fifo_count_o !== 3'd1) $display("FAIL b2b_count_pop2: got %0d, required 1", fifo_count_o);
                else passes++;
                check_frame(8'hFF, 0);
                checks++;
                if (fifo_count_o !== 3'd0) $display("FAIL b2b_count_pop3: got %0d, required 0", fifo_count_o);
                else passes++;
                check_frame(8'h3C, 0);
            end
        join
        checks++;
        if ({busy_o, tx_o} !== 2'b01) $display("FAIL b2b_idle: busy/tx=%b/%b, required 0/1", busy_o, tx_o);
        else passes++;
    endtask

    task automatic test_full();
        logic [7:0] bytes [6];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            begin
                int w;
                for (int i = 0; i < 5; i++) push(bytes[i], w);
                checks++;
                if ({tx_ready_o, fifo_count_o} !== {1'b0, 3'd4}) begin
                    $display("FAIL full_flag: ready/count=%b/%0d, required 0/4", tx_ready_o, fifo_count_o);
                end else begin
                    passes++;
                end
                push(bytes[5], w);
                checks++;
                if (w != 97) $display("FAIL full_stall_cycles: got %0d, required 97", w);
                else passes++;
                checks++;
                if (fifo_count_o !== 3'd4) $display("FAIL full_refill: count=%0d, required 4", fifo_count_o);
                else passes++;
            end
            begin
                check_frame(bytes[0], 3);
                for (int i = 1; i < 6; i++) check_frame(bytes[i], 0);
            end
        join
        checks++;
        if ({busy_o, fifo_count_o} !== {1'b0, 3'd0}) $display("FAIL full_drained: busy/count=%b/%0d, required 0/0", busy_o, fifo_count_o);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int bad;
        push(8'hC3, w);
        push(8'h81, w);
        repeat (45) @(negedge clk_i);
        // Now in data bit 3 of 0xC3, which is a 0
        checks++;
        if ({tx_o, fifo_count_o} !== {1'b0, 3'd1}) $display("FAIL midframe_before: tx/count=%b/%0d, required 0/1", tx_o, fifo_count_o);
        else passes++;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (tx_ready_o !== 1'b0) $display("FAIL midframe_ready_in_reset: got %b, required 0", tx_ready_o);
        else passes++;
        @(negedge clk_i);
        checks++;
        if ({tx_o, fifo_count_o, busy_o} !== {1'b1, 3'd0, 1'b0}) begin
            $display("FAIL midframe_reset_edge: tx/count/busy=%b/%0d/%b, required 1/0/0", tx_o, fifo_count_o, busy_o);
        end else begin
            passes++;
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL midframe_quiet: %0d of 200 cycles not idle, required 0", bad);
        else passes++;
        $display("reset mid-frame test done");
    endtask

    task automatic test_push_during_pop();
        tx_data_i  = 8'h5A;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({tx_o, fifo_count_o, busy_o} !== {1'b1, 3'd1, 1'b1}) begin
            $display("FAIL pdp_queued: tx/count/busy=%b/%0d/%b, required 1/1/1", tx_o, fifo_count_o, busy_o);
        end else begin
            passes++;
        end
        tx_data_i = 8'h7E;
        fork
            begin
                @(negedge clk_i);
                tx_valid_i = 1'b0;
                checks++;
                if ({tx_o, fifo_count_o} !== {1'b0, 3'd1}) $display("FAIL pdp_after_edge: tx/count=%b/%0d, required 0/1", tx_o, fifo_count_o);
                else passes++;
                repeat (50) @(negedge clk_i);
                checks++;
                if (fifo_count_o !== 3'd1) $display("FAIL pdp_mid_count: got %0d, required 1", fifo_count_o);
                else passes++;
            end
            begin
                check_frame(8'h5A, 1);
                check_frame(8'h7E, 0);
            end
        join
        checks++;
        if ({busy_o, fifo_count_o} !== {1'b0, 3'd0}) $display("FAIL pdp_done: busy/count=%b/%0d, required 0/0", busy_o, fifo_count_o);
        else passes++;
    endtask

    initial begin
        test_reset();
        repeat (2) @(negedge clk_i);
        test_single_byte();
        repeat (3) @(negedge clk_i);
        test_back_to_back();
        repeat (3) @(negedge clk_i);
        test_full();
        repeat (3) @(negedge clk_i);
        test_reset_mid_frame();
        test_push_during_pop();
        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
